// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: x/y counters, region FSMs, registered sync/display/strobes.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          h_sync,
  output logic          v_sync,
  output logic          display,
  output logic          line_start,
  output logic          frame_start,
  output logic          animate,
  output logic [7:0]    frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << CW)) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > (1 << CW)) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end

  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_FP_START  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYN_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_BP_START  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_FP_START  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYN_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_BP_START  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ACT      = 1'(HS_POL);
  localparam logic          VS_ACT      = 1'(VS_POL);

  typedef enum logic [1:0] {H_ACT, H_FPS, H_SYN, H_BPS} h_state_e;
  typedef enum logic [1:0] {V_ACT, V_FPS, V_SYN, V_BPS} v_state_e;

  h_state_e        h_state_q, h_state_d;
  v_state_e        v_state_q, v_state_d;
  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  logic            h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic            display_q, display_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
  logic            animate_q, animate_d;
  logic            x_wrap, y_wrap;

  // Outputs are computed from the next-state values so they line up with x/y.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    x_wrap    = 1'b0;
    y_wrap    = 1'b0;
    if (pix_en) begin
      x_wrap = (x_q == H_LAST);
      x_d    = x_wrap ? '0 : x_q + 1'b1;
      unique case (h_state_q)
        H_ACT: if (x_d == H_FP_START)  h_state_d = H_FPS;
        H_FPS: if (x_d == H_SYN_START) h_state_d = H_SYN;
        H_SYN: if (x_d == H_BP_START)  h_state_d = H_BPS;
        H_BPS: if (x_wrap)             h_state_d = H_ACT;
        default:                       h_state_d = H_BPS;
      endcase
      if (x_wrap) begin
        y_wrap = (y_q == V_LAST);
        y_d    = y_wrap ? '0 : y_q + 1'b1;
        unique case (v_state_q)
          V_ACT: if (y_d == V_FP_START)  v_state_d = V_FPS;
          V_FPS: if (y_d == V_SYN_START) v_state_d = V_SYN;
          V_SYN: if (y_d == V_BP_START)  v_state_d = V_BPS;
          V_BPS: if (y_wrap)             v_state_d = V_ACT;
          default:                       v_state_d = V_BPS;
        endcase
      end
    end
    h_sync_d      = (h_state_d == H_SYN) ? HS_ACT : ~HS_ACT;
    v_sync_d      = (v_state_d == V_SYN) ? VS_ACT : ~VS_ACT;
    display_d     = (h_state_d == H_ACT) && (v_state_d == V_ACT);
    line_start_d  = x_wrap;
    frame_start_d = x_wrap && y_wrap;
    animate_d     = x_wrap && (y_d == V_FP_START);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      h_state_q     <= H_BPS;
      v_state_q     <= V_BPS;
      h_sync_q      <= ~HS_ACT;
      v_sync_q      <= ~VS_ACT;
      display_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      animate_q     <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      display_q     <= display_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      animate_q     <= animate_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (x_wrap && y_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign display     = display_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign animate     = animate_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-geometry DUTs (both polarities) plus a default-geometry DUT,
// checked against a position-arithmetic reference model and a directed vector table.
module tb_vga_timing_gen;

  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 2;
  localparam int SCW = 5;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam logic [7:0] FC1 = 8'd1;
  localparam logic [7:0] FC2 = 8'd2;
`else
  localparam logic [7:0] FC1 = 8'd0;
  localparam logic [7:0] FC2 = 8'd0;
`endif

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        hs;
    logic        vs;
    logic        disp;
    logic        ls;
    logic        fs;
    logic        an;
    logic [7:0]  fc;
  } outs_t;

  typedef struct {
    int    edges;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_en;

  logic [SCW-1:0] x0, y0, x1, y1;
  logic [9:0]     x2, y2;
  logic hs0, vs0, d0, ls0, fs0, an0;
  logic hs1, vs1, d1, ls1, fs1, an1;
  logic hs2, vs2, d2, ls2, fs2, an2;
  logic [7:0] fc0, fc1, fc2;

  int n_chk = 0;
  int n_err = 0;
  int adv   = 0;
  bit moved = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(0), .VS_POL(0), .CW(SCW)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x0), .y(y0),
    .h_sync(hs0), .v_sync(vs0), .display(d0), .line_start(ls0),
    .frame_start(fs0), .animate(an0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1), .VS_POL(1), .CW(SCW)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x1), .y(y1),
    .h_sync(hs1), .v_sync(vs1), .display(d1), .line_start(ls1),
    .frame_start(fs1), .animate(an1), .frame_cnt(fc1)
  );

  vga_timing_gen u_dut2 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x2), .y(y2),
    .h_sync(hs2), .v_sync(vs2), .display(d2), .line_start(ls2),
    .frame_start(fs2), .animate(an2), .frame_cnt(fc2)
  );

  // Expected outputs from the number of pixel advances since reset release.
  function automatic outs_t model(int ha, int hf, int hsw, int hb, int va, int vf, int vsw, int vb,
                                  bit hpol, bit vpol, int a, bit mv);
    int ht, vt, p, xx, yy;
    outs_t o;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p  = a - 1;
    if (a == 0) begin
      xx = ht - 1;
      yy = vt - 1;
    end else begin
      xx = p % ht;
      yy = (p / ht) % vt;
    end
    o.x    = 16'(xx);
    o.y    = 16'(yy);
    o.disp = (a != 0) && (xx < ha) && (yy < va);
    o.hs   = (xx >= ha + hf && xx < ha + hf + hsw) ? hpol : ~hpol;
    o.vs   = (yy >= va + vf && yy < va + vf + vsw) ? vpol : ~vpol;
    o.ls   = mv && (xx == 0);
    o.fs   = mv && (xx == 0) && (yy == 0);
    o.an   = mv && (xx == 0) && (yy == va);
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.fc   = (a == 0) ? 8'd0 : 8'((p / (ht * vt) + 1) % 256);
`else
    o.fc   = 8'd0;
`endif
    return o;
  endfunction

  task automatic check(string name, outs_t act, outs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t adv=%0d: got x=%0d y=%0d hs=%b vs=%b disp=%b ls=%b fs=%b an=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b disp=%b ls=%b fs=%b an=%b fc=%0d",
               name, $time, adv, act.x, act.y, act.hs, act.vs, act.disp, act.ls, act.fs, act.an, act.fc,
               exp.x, exp.y, exp.hs, exp.vs, exp.disp, exp.ls, exp.fs, exp.an, exp.fc);
    end
  endtask

  function automatic outs_t act0();
    return '{x: 16'(x0), y: 16'(y0), hs: hs0, vs: vs0, disp: d0, ls: ls0, fs: fs0, an: an0, fc: fc0};
  endfunction

  task automatic check_all(string tag);
    outs_t a1, a2;
    a1 = '{x: 16'(x1), y: 16'(y1), hs: hs1, vs: vs1, disp: d1, ls: ls1, fs: fs1, an: an1, fc: fc1};
    a2 = '{x: 16'(x2), y: 16'(y2), hs: hs2, vs: vs2, disp: d2, ls: ls2, fs: fs2, an: an2, fc: fc2};
    check({tag, "_small"}, act0(), model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0, 1'b0, adv, moved));
    check({tag, "_pol1"},  a1,     model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, 1'b1, adv, moved));
    check({tag, "_dflt"},  a2,     model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, adv, moved));
  endtask

  task automatic step(bit pe);
    pix_en = pe;
    @(posedge clk);
    if (rst_n) begin
      moved = pe;
      if (pe) adv++;
    end else begin
      moved = 1'b0;
    end
    #1;
    check_all("step");
  endtask

  // Reset asserted between clock edges; state must clear before any edge arrives.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    adv   = 0;
    moved = 1'b0;
    check_all("async_rst");
    pix_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int per;
    bit found;

    tbl[0]  = '{0,   '{x:16'd15, y:16'd10, hs:1, vs:1, disp:0, ls:0, fs:0, an:0, fc:8'd0}};
    tbl[1]  = '{1,   '{x:16'd0,  y:16'd0,  hs:1, vs:1, disp:1, ls:1, fs:1, an:0, fc:FC1}};
    tbl[2]  = '{8,   '{x:16'd7,  y:16'd0,  hs:1, vs:1, disp:1, ls:0, fs:0, an:0, fc:FC1}};
    tbl[3]  = '{9,   '{x:16'd8,  y:16'd0,  hs:1, vs:1, disp:0, ls:0, fs:0, an:0, fc:FC1}};
    tbl[4]  = '{11,  '{x:16'd10, y:16'd0,  hs:0, vs:1, disp:0, ls:0, fs:0, an:0, fc:FC1}};
    tbl[5]  = '{13,  '{x:16'd12, y:16'd0,  hs:0, vs:1, disp:0, ls:0, fs:0, an:0, fc:FC1}};
    tbl[6]  = '{14,  '{x:16'd13, y:16'd0,  hs:1, vs:1, disp:0, ls:0, fs:0, an:0, fc:FC1}};
    tbl[7]  = '{17,  '{x:16'd0,  y:16'd1,  hs:1, vs:1, disp:1, ls:1, fs:0, an:0, fc:FC1}};
    tbl[8]  = '{97,  '{x:16'd0,  y:16'd6,  hs:1, vs:1, disp:0, ls:1, fs:0, an:1, fc:FC1}};
    tbl[9]  = '{113, '{x:16'd0,  y:16'd7,  hs:1, vs:0, disp:0, ls:1, fs:0, an:0, fc:FC1}};
    tbl[10] = '{129, '{x:16'd0,  y:16'd8,  hs:1, vs:0, disp:0, ls:1, fs:0, an:0, fc:FC1}};
    tbl[11] = '{145, '{x:16'd0,  y:16'd9,  hs:1, vs:1, disp:0, ls:1, fs:0, an:0, fc:FC1}};
    tbl[12] = '{176, '{x:16'd15, y:16'd10, hs:1, vs:1, disp:0, ls:0, fs:0, an:0, fc:FC1}};
    tbl[13] = '{177, '{x:16'd0,  y:16'd0,  hs:1, vs:1, disp:1, ls:1, fs:1, an:0, fc:FC2}};

    rst_n  = 1'b1;
    pix_en = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("por");
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_reset();
      for (int k = 0; k < tbl[i].edges; k++) step(1'b1);
      check($sformatf("vec%0d", i), act0(), tbl[i].exp);
    end

    // Random enable pattern, then strict alternation.
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 3) != 0);
    for (int i = 0; i < 400; i++) step(i % 2 == 0);

    // Reset mid-frame, then the post-release sequence.
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b1);

    // Frame period with pix_en alternating 1/0.
    do_reset();
    step(1'b1);
    per   = 0;
    found = 1'b0;
    for (int i = 1; i <= 1000 && !found; i++) begin
      step(i % 2 == 0);
      if (fs0) begin
        per   = i;
        found = 1'b1;
      end
    end
    n_chk++;
    if (per != 2 * 176) begin
      n_err++;
      $display("FAIL frame_period_alt: got %0d clks, expected %0d", per, 2 * 176);
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    do_reset();
    for (int i = 0; i < 256 * 176 + 20; i++) step(1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
